lfu_replacer_param: RTL and testbench
=====================================

Name: lfu_replacer_param

Overview:
- Parametrised least-frequently-used replacement selector for an N-entry buffer pool.
- Keeps one saturating reference-frequency counter per buffer. When any counter would overflow, all counters are aged (halved).
- Registers the index of the next buffer to replace, updated on each new-buffer request.
- Sits beside the buffer manager: the manager reports hits via the ref port and consumes buf_num_replc when it allocates.

Parameters:
- NUM_BUF, 4, number of buffers tracked (2..64; need not be a power of 2).
- CNT_W, 3, width of each frequency counter (2..8). Counter maximum MAX = 2^CNT_W - 1.
- IDX_W, derived localparam = max(1, clog2(NUM_BUF)), width of all buffer-index ports.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- new_buf_req  input  1  allocation request: current buf_num_replc is being refilled this cycle.
- ref_valid  input  1  qualifies ref_buf_numbr as a reference (hit) this cycle.
- ref_buf_numbr  input  IDX_W  index of the referenced buffer.
- buf_num_replc  output  IDX_W  registered index of the buffer to replace next.
- aging_pulse  output  1  registered; high for one cycle after an aging event.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: every counter = 1, buf_num_replc = 0, aging_pulse = 0. Reset overrides all inputs in the same edge. Asserting reset mid-operation discards all history.
- Counters never hold 0. Their range is 1..MAX.
- Reference, counted only when ref_valid=1, new_buf_req=0 and ref_buf_numbr < NUM_BUF:
  - If cnt[ref] < MAX: cnt[ref] <= cnt[ref] + 1. Other counters hold.
  - If cnt[ref] == MAX (aging event):
    - every other counter i <= max(1, cnt[i] >> 1);
    - cnt[ref] <= (MAX >> 1) + 1;
    - aging_pulse <= 1 next cycle.
  - Out-of-range index (>= NUM_BUF): ignored, no state change.
- Allocation, when new_buf_req=1:
  - Victim = the index with the minimum counter value among all buffers except the current buf_num_replc. The victim is computed from the counter values before this edge.
  - Ties resolve to the lowest index.
  - buf_num_replc <= victim. The new value is visible one cycle after new_buf_req is sampled.
  - cnt[current buf_num_replc] <= 1, because that buffer is freshly loaded. Other counters hold.
  - NUM_BUF=1: buf_num_replc stays 0 and cnt[0] <= 1.
- Simultaneous new_buf_req and ref_valid: allocation wins, the reference is dropped, and no aging occurs.
- Back-to-back new_buf_req: each cycle uses the buf_num_replc registered on the previous edge.
- aging_pulse is 0 in every cycle that does not follow an aging event.
- Victim search is combinational over NUM_BUF entries. Latency from new_buf_req to buf_num_replc is exactly 1 cycle.
- No internal state machine beyond the counters and registered outputs. buf_num_replc holds its value when new_buf_req=0.

Optional Feature:
- Macro: LFU_LOCK_EN.
- Defined:
  - Adds input lock_mask [NUM_BUF-1:0]. Locked buffers (bit=1) are excluded from victim selection, in addition to the current buf_num_replc.
  - If every candidate is locked, buf_num_replc holds its current value.
  - Locked buffers still count references and still age.
- Not defined: no lock_mask port, and every buffer except the current buf_num_replc is a candidate.

Test Plan (NUM_BUF=4, CNT_W=3, MAX=7 unless noted):
- Reset: hold rst=1 for 2 cycles with random inputs -> buf_num_replc=0, aging_pulse=0, all counters=1.
- Tie-break: after reset, pulse new_buf_req -> next cycle buf_num_replc=1 (buf 0 excluded, all counts 1), cnt0=1.
- LFU choice:
  - After reset, ref buf0 x2, buf1 x1, buf2 x3 -> counts 3,2,4,1.
  - Then new_buf_req -> buf_num_replc=3, cnt0=1.
  - Then new_buf_req again -> candidates 0,1,2 with counts 1,2,4 -> buf_num_replc=0, cnt3=1.
- Aging:
  - After reset, ref buf1 x6 -> cnt1=7.
  - 7th ref to buf1 -> cnt1=4, cnt0/cnt2/cnt3=1, aging_pulse=1 for exactly one cycle.
  - A further ref to buf1 -> cnt1=5, aging_pulse=0.
- Collision: ref_valid=1 with ref_buf_numbr=2 in the same cycle as new_buf_req=1 -> cnt2 unchanged. Also with NUM_BUF=6, ref_buf_numbr=7 -> no counter changes.
- LFU_LOCK_EN:
  - lock_mask=4'b1110 with buf_num_replc=0 and new_buf_req -> all candidates locked, buf_num_replc stays 0.
  - lock_mask=4'b1010 with counts 1,5,3,1 and buf_num_replc=0 -> buf_num_replc=2.

Source files
------------

// File: rtl/lfu_replacer_param.sv
// lfu_replacer_param: least-frequently-used victim selector for an N-entry buffer pool.
// One saturating frequency counter per buffer (range 1..MAX); a hit on a saturated
// counter ages the whole pool. The next victim index is registered on each allocation.
// Optional feature macro: LFU_LOCK_EN adds i_lock_mask to exclude buffers from selection.
module lfu_replacer_param #(
  parameter int unsigned NUM_BUF = 4,
  parameter int unsigned CNT_W   = 3,
  localparam int unsigned IDX_W  = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_new_buf_req,
  input  logic             i_ref_valid,
  input  logic [IDX_W-1:0] i_ref_buf_numbr,
`ifdef LFU_LOCK_EN
  input  logic [NUM_BUF-1:0] i_lock_mask,
`endif
  output logic [IDX_W-1:0] o_buf_num_replc,
  output logic             o_aging_pulse
);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  // A saturated counter restarts just above the aged midpoint so it stays the hottest.
  localparam logic [CNT_W-1:0] CntAged = (CntMax >> 1) + CntOne;

  logic [NUM_BUF-1:0][CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0]              r_replc;
  logic                          r_aging;

  logic [NUM_BUF-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0]              w_replc_nxt;
  logic                          w_aging_nxt;
  logic [NUM_BUF-1:0]            w_locked;
  logic                          w_found;
  logic [IDX_W-1:0]              w_victim;
  logic [CNT_W-1:0]              w_min;
  logic [CNT_W-1:0]              w_ref_cnt;
  logic                          w_ref_ok;

`ifdef LFU_LOCK_EN
  assign w_locked = i_lock_mask;
`else
  assign w_locked = '0;
`endif

  // Reference is counted only when no allocation competes and the index is in range.
  assign w_ref_ok = i_ref_valid && !i_new_buf_req && (32'(i_ref_buf_numbr) < NUM_BUF);

  // Victim search: lowest count among unlocked buffers other than the current victim;
  // strict less-than keeps the lowest index on ties.
  always_comb begin
    w_found  = 1'b0;
    w_victim = r_replc;
    w_min    = CntMax;
    for (int i = 0; i < NUM_BUF; i++) begin
      if ((IDX_W'(i) != r_replc) && !w_locked[i] && (!w_found || (r_cnt[i] < w_min))) begin
        w_found  = 1'b1;
        w_min    = r_cnt[i];
        w_victim = IDX_W'(i);
      end
    end
  end

  // Current count of the referenced buffer.
  always_comb begin
    w_ref_cnt = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (IDX_W'(i) == i_ref_buf_numbr) begin
        w_ref_cnt = r_cnt[i];
      end
    end
  end

  // Next-state for counters, victim register and aging pulse.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_replc_nxt = r_replc;
    w_aging_nxt = 1'b0;
    if (i_new_buf_req) begin
      for (int i = 0; i < NUM_BUF; i++) begin
        if (IDX_W'(i) == r_replc) begin
          w_cnt_nxt[i] = CntOne;
        end
      end
      // With every candidate excluded the victim register simply holds.
      if (w_found) begin
        w_replc_nxt = w_victim;
      end
    end else if (w_ref_ok) begin
      if (w_ref_cnt == CntMax) begin
        w_aging_nxt = 1'b1;
        for (int i = 0; i < NUM_BUF; i++) begin
          if (IDX_W'(i) == i_ref_buf_numbr) begin
            w_cnt_nxt[i] = CntAged;
          end else if ((r_cnt[i] >> 1) == '0) begin
            w_cnt_nxt[i] = CntOne;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] >> 1;
          end
        end
      end else begin
        for (int i = 0; i < NUM_BUF; i++) begin
          if (IDX_W'(i) == i_ref_buf_numbr) begin
            w_cnt_nxt[i] = r_cnt[i] + CntOne;
          end
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= {NUM_BUF{CntOne}};
      r_replc <= '0;
      r_aging <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_replc <= w_replc_nxt;
      r_aging <= w_aging_nxt;
    end
  end

  assign o_buf_num_replc = r_replc;
  assign o_aging_pulse   = r_aging;

endmodule

// File: tb/tb_lfu_replacer_param.sv
// Scoreboard bench for lfu_replacer_param: a 4-buffer and a 6-buffer instance.
// Driver pushes hand-computed expectations; a monitor pops and compares each cycle.
module tb_lfu_replacer_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_req, a_rv;
  logic [1:0] a_ridx, a_replc;
  logic       a_aging;
  logic       b_req, b_rv;
  logic [2:0] b_ridx, b_replc;
  logic       b_aging;
`ifdef LFU_LOCK_EN
  logic [3:0] a_lock;
  logic [5:0] b_lock;
`endif

  lfu_replacer_param #(.NUM_BUF(4), .CNT_W(3)) dut0 (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_new_buf_req   (a_req),
    .i_ref_valid     (a_rv),
    .i_ref_buf_numbr (a_ridx),
`ifdef LFU_LOCK_EN
    .i_lock_mask     (a_lock),
`endif
    .o_buf_num_replc (a_replc),
    .o_aging_pulse   (a_aging)
  );

  lfu_replacer_param #(.NUM_BUF(6), .CNT_W(3)) dut1 (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_new_buf_req   (b_req),
    .i_ref_valid     (b_rv),
    .i_ref_buf_numbr (b_ridx),
`ifdef LFU_LOCK_EN
    .i_lock_mask     (b_lock),
`endif
    .o_buf_num_replc (b_replc),
    .o_aging_pulse   (b_aging)
  );

  typedef struct {
    int          sel;
    int          due;
    logic [2:0]  replc;
    logic        aging;
    logic [17:0] cnt;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] pk4(int c0, int c1, int c2, int c3);
    logic [17:0] v;
    v = {6'd0, 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    return v;
  endfunction

  function automatic logic [17:0] pk6(int c0, int c1, int c2, int c3, int c4, int c5);
    logic [17:0] v;
    v = {3'(c5), 3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    return v;
  endfunction

  task automatic chk(string name, string what, logic [17:0] act, logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h, expected %0h", name, what, act, exp);
    end
  endtask

  // Monitor: compare every expectation due at the edge just passed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due != cyc) begin
          chk(e.name, "due", 18'(cyc), 18'(e.due));
        end else if (e.sel == 0) begin
          chk(e.name, "replc", {16'd0, a_replc}, {15'd0, e.replc});
          chk(e.name, "aging", {17'd0, a_aging}, {17'd0, e.aging});
          chk(e.name, "cnt", {6'd0, dut0.r_cnt}, e.cnt);
        end else begin
          chk(e.name, "replc", {15'd0, b_replc}, {15'd0, e.replc});
          chk(e.name, "aging", {17'd0, b_aging}, {17'd0, e.aging});
          chk(e.name, "cnt", dut1.r_cnt, e.cnt);
        end
      end
    end
  end

  task automatic idle_inputs();
    a_req = 0; a_rv = 0; a_ridx = 0;
    b_req = 0; b_rv = 0; b_ridx = 0;
`ifdef LFU_LOCK_EN
    a_lock = 0; b_lock = 0;
`endif
  endtask

  task automatic push(int sel, int er, bit ea, logic [17:0] ec, string nm);
    exp_t e;
    e.sel = sel; e.due = cyc + 1; e.replc = 3'(er); e.aging = ea; e.cnt = ec; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic do_reset(string nm);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      rst = 1;
      a_req = 1'($urandom); a_rv = 1'($urandom); a_ridx = 2'($urandom);
      b_req = 1'($urandom); b_rv = 1'($urandom); b_ridx = 3'($urandom);
`ifdef LFU_LOCK_EN
      a_lock = 4'($urandom); b_lock = 6'($urandom);
`endif
      push(0, 0, 0, pk4(1, 1, 1, 1), nm);
      push(1, 0, 0, pk6(1, 1, 1, 1, 1, 1), nm);
    end
  endtask

  // One cycle on one instance; the other instance sees idle inputs.
  task automatic step(int sel, bit req, bit rv, int ridx, int lock, int er, bit ea,
                      logic [17:0] ec, string nm);
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();
    if (sel == 0) begin
      a_req = req; a_rv = rv; a_ridx = 2'(ridx);
`ifdef LFU_LOCK_EN
      a_lock = 4'(lock);
`endif
    end else begin
      b_req = req; b_rv = rv; b_ridx = 3'(ridx);
`ifdef LFU_LOCK_EN
      b_lock = 6'(lock);
`endif
    end
    push(sel, er, ea, ec, nm);
  endtask

  initial begin
    rst = 1;
    idle_inputs();

    // Reset, then tie-break: all counts 1, current victim 0 excluded -> 1.
    do_reset("reset");
    step(0, 1, 0, 0, 0, 1, 0, pk4(1, 1, 1, 1), "tiebreak");

    // LFU choice.
    do_reset("reset2");
    step(0, 0, 1, 0, 0, 0, 0, pk4(2, 1, 1, 1), "ref0a");
    step(0, 0, 1, 0, 0, 0, 0, pk4(3, 1, 1, 1), "ref0b");
    step(0, 0, 1, 1, 0, 0, 0, pk4(3, 2, 1, 1), "ref1");
    step(0, 0, 1, 2, 0, 0, 0, pk4(3, 2, 2, 1), "ref2a");
    step(0, 0, 1, 2, 0, 0, 0, pk4(3, 2, 3, 1), "ref2b");
    step(0, 0, 1, 2, 0, 0, 0, pk4(3, 2, 4, 1), "ref2c");
    step(0, 1, 0, 0, 0, 3, 0, pk4(1, 2, 4, 1), "alloc1");
    step(0, 1, 0, 0, 0, 0, 0, pk4(1, 2, 4, 1), "alloc2");
    // Collision: ref to buf2 dropped; victim among 1,2,3 (2,4,1) -> 3.
    step(0, 1, 1, 2, 0, 3, 0, pk4(1, 2, 4, 1), "collide");
    step(0, 0, 0, 0, 0, 3, 0, pk4(1, 2, 4, 1), "hold");

    // Aging on saturated buf1.
    do_reset("reset3");
    for (int k = 2; k <= 7; k++) step(0, 0, 1, 1, 0, 0, 0, pk4(1, k, 1, 1), "ref1sat");
    step(0, 0, 1, 1, 0, 0, 1, pk4(1, 4, 1, 1), "age");
    step(0, 0, 1, 1, 0, 0, 0, pk4(1, 5, 1, 1), "postage");
    step(0, 0, 0, 0, 0, 0, 0, pk4(1, 5, 1, 1), "pulseoff");

    // Aging halves the other counters with a floor of 1.
    do_reset("reset4");
    for (int k = 2; k <= 5; k++) step(0, 0, 1, 0, 0, 0, 0, pk4(k, 1, 1, 1), "ref0up");
    step(0, 0, 1, 3, 0, 0, 0, pk4(5, 1, 1, 2), "ref3");
    for (int k = 2; k <= 7; k++) step(0, 0, 1, 1, 0, 0, 0, pk4(5, k, 1, 2), "ref1up");
    step(0, 0, 1, 1, 0, 0, 1, pk4(2, 4, 1, 1), "agehalf");

    // Six-buffer instance: out-of-range references ignored.
    do_reset("reset5");
    step(1, 0, 1, 3, 0, 0, 0, pk6(1, 1, 1, 2, 1, 1), "b_ref3");
    step(1, 0, 1, 7, 0, 0, 0, pk6(1, 1, 1, 2, 1, 1), "b_ref7");
    step(1, 0, 1, 6, 0, 0, 0, pk6(1, 1, 1, 2, 1, 1), "b_ref6");
    step(1, 0, 1, 5, 0, 0, 0, pk6(1, 1, 1, 2, 1, 2), "b_ref5");
    step(1, 1, 0, 0, 0, 1, 0, pk6(1, 1, 1, 2, 1, 2), "b_alloc");

`ifdef LFU_LOCK_EN
    do_reset("reset6");
    step(0, 1, 0, 0, 4'b1110, 0, 0, pk4(1, 1, 1, 1), "lockall");
    do_reset("reset7");
    for (int k = 2; k <= 5; k++) step(0, 0, 1, 1, 0, 0, 0, pk4(1, k, 1, 1), "lref1");
    step(0, 0, 1, 2, 0, 0, 0, pk4(1, 5, 2, 1), "lref2a");
    step(0, 0, 1, 2, 0, 0, 0, pk4(1, 5, 3, 1), "lref2b");
    step(0, 1, 0, 0, 4'b1010, 2, 0, pk4(1, 5, 3, 1), "lockpart");
`endif

    @(posedge clk); #1;
    idle_inputs();
    rst = 0;
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
